// File: rtl/bcd_time_keeper_pkg.sv
// rtl/bcd_time_keeper_pkg.sv - shared state type, BCD limits and BCD helper functions
package bcd_time_keeper_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } set_state_e;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h23;

    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max);
        if (v == max) begin
            return 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // With both nibbles <= 9 a raw byte compare orders BCD values correctly.
    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Returns {pm, hh_12} for a 24h BCD hour.
    function automatic logic [8:0] to_12h(input logic [7:0] h);
        case (h)
            8'h00:   return {1'b0, 8'h12};
            8'h12:   return {1'b1, 8'h12};
            8'h13:   return {1'b1, 8'h01};
            8'h14:   return {1'b1, 8'h02};
            8'h15:   return {1'b1, 8'h03};
            8'h16:   return {1'b1, 8'h04};
            8'h17:   return {1'b1, 8'h05};
            8'h18:   return {1'b1, 8'h06};
            8'h19:   return {1'b1, 8'h07};
            8'h20:   return {1'b1, 8'h08};
            8'h21:   return {1'b1, 8'h09};
            8'h22:   return {1'b1, 8'h10};
            8'h23:   return {1'b1, 8'h11};
            default: return {1'b0, h};
        endcase
    endfunction

endpackage

// File: rtl/bcd_time_keeper_counter.sv
// rtl/bcd_time_keeper_counter.sv - two-digit BCD modulo counter with load and clear
module bcd_mod_counter
    import bcd_time_keeper_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic       ld,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       carry
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (clr) begin
            q_d = 8'h00;
        end else if (inc) begin
            q_d = bcd_next(q_q, MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 8'h00;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc && (q_q == MAX);

endmodule

// File: rtl/bcd_time_keeper.sv
// rtl/bcd_time_keeper.sv - HH:MM:SS BCD time keeper with set FSM, checked load, 12/24h display
// Optional alarm when BCD_TIME_KEEPER_ALARM_EN is defined.
module bcd_time_keeper
    import bcd_time_keeper_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [7:0] d_h,
    input  logic [7:0] d_m,
    input  logic [7:0] d_s,
    input  logic       set,
    input  logic       add,
    input  logic       mode_12h,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic [1:0] setting,
    output logic       sec_tick,
    output logic       day_carry,
    output logic       ld_err
`ifdef BCD_TIME_KEEPER_ALARM_EN
    ,
    input  logic [7:0] alarm_h,
    input  logic [7:0] alarm_m,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic       alarm
`endif
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    set_state_e       state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [7:0]       hr_q, min_q, sec_q;
    logic             hr_carry, min_carry, sec_carry;
    logic             ld_ok, ld_take, set_ev, add_ev, running, tick;
    logic [8:0]       disp_12h;

    assign ld_ok   = bcd_in_range(d_h, HR_MAX) && bcd_in_range(d_m, MIN_MAX)
                     && bcd_in_range(d_s, SEC_MAX);
    assign ld_take = ld && ld_ok;
    // Any load, accepted or not, swallows a coincident set or add.
    assign set_ev  = set && !ld;
    assign add_ev  = add && !ld;
    assign running = (state_q == ST_RUN);
    assign tick    = !rst && !ld && running && !set && (presc_q == TICK_LAST);

    always_comb begin
        presc_d = presc_q;
        if (ld) begin
            if (ld_ok) begin
                presc_d = '0;
            end
        end else if (!running || set) begin
            presc_d = '0;
        end else if (presc_q == TICK_LAST) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (ld_take) begin
            state_d = ST_RUN;
        end else if (set_ev) begin
            case (state_q)
                ST_RUN:   state_d = ST_SET_H;
                ST_SET_H: state_d = ST_SET_M;
                ST_SET_M: state_d = ST_SET_S;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (tick),
        .clr   (add_ev && (state_q == ST_SET_S)),
        .ld    (ld_take),
        .d     (d_s),
        .q     (sec_q),
        .carry (sec_carry)
    );

    // sec_carry only exists in RUN, so an add in SET_M cannot ripple into hours.
    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_carry || (add_ev && (state_q == ST_SET_M))),
        .clr   (1'b0),
        .ld    (ld_take),
        .d     (d_m),
        .q     (min_q),
        .carry (min_carry)
    );

    bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
        .clk   (clk),
        .rst   (rst),
        .inc   ((sec_carry && min_carry) || (add_ev && (state_q == ST_SET_H))),
        .clr   (1'b0),
        .ld    (ld_take),
        .d     (d_h),
        .q     (hr_q),
        .carry (hr_carry)
    );

    assign disp_12h  = to_12h(hr_q);
    assign hh        = mode_12h ? disp_12h[7:0] : hr_q;
    assign pm        = mode_12h && disp_12h[8];
    assign mm        = min_q;
    assign ss        = sec_q;
    assign setting   = state_q;
    assign sec_tick  = tick;
    assign day_carry = sec_carry && min_carry && hr_carry;
    assign ld_err    = ld && !ld_ok && !rst;

`ifdef BCD_TIME_KEEPER_ALARM_EN
    logic       alarm_q, alarm_d;
    logic [7:0] hr_after;
    logic       alarm_hit;

    // Alarm targets HH:MM:00, so only a tick rolling seconds over can match.
    assign hr_after  = (min_q == MIN_MAX) ? bcd_next(hr_q, HR_MAX) : hr_q;
    assign alarm_hit = tick && (sec_q == SEC_MAX)
                       && (bcd_next(min_q, MIN_MAX) == alarm_m) && (hr_after == alarm_h);

    always_comb begin
        alarm_d = alarm_q;
        if (alarm_ack || !alarm_arm) begin
            alarm_d = 1'b0;
        end else if (alarm_hit) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_bcd_time_keeper.sv
// tb/tb_bcd_time_keeper.sv - self-checking bench for bcd_time_keeper with TICK_DIV=4
module tb_bcd_time_keeper;

    logic       clk = 1'b0;
    logic       rst, ld, set, add, mode_12h;
    logic [7:0] d_h, d_m, d_s;
    logic [7:0] hh, mm, ss;
    logic       pm, sec_tick, day_carry, ld_err;
    logic [1:0] setting;
`ifdef BCD_TIME_KEEPER_ALARM_EN
    logic [7:0] alarm_h, alarm_m;
    logic       alarm_arm, alarm_ack, alarm;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_time_keeper #(.TICK_DIV(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .d_h       (d_h),
        .d_m       (d_m),
        .d_s       (d_s),
        .set       (set),
        .add       (add),
        .mode_12h  (mode_12h),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .pm        (pm),
        .setting   (setting),
        .sec_tick  (sec_tick),
        .day_carry (day_carry),
        .ld_err    (ld_err)
`ifdef BCD_TIME_KEEPER_ALARM_EN
        ,
        .alarm_h   (alarm_h),
        .alarm_m   (alarm_m),
        .alarm_arm (alarm_arm),
        .alarm_ack (alarm_ack),
        .alarm     (alarm)
`endif
    );

    typedef struct {
        logic [7:0] h, m, s;
        logic       mode;
        logic       err;
        logic [7:0] eh, em, es;
        logic       epm;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_time(input string nm, input logic [7:0] eh, input logic [7:0] em,
                            input logic [7:0] es);
        chk({nm, " hh"}, hh, eh);
        chk({nm, " mm"}, mm, em);
        chk({nm, " ss"}, ss, es);
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        ld = 1'b1; d_h = h; d_m = m; d_s = s;
        cyc();
        ld = 1'b0;
    endtask

    task automatic pulse_set();
        set = 1'b1;
        cyc();
        set = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'h13, 8'h05, 8'h00, 1'b1, 1'b0, 8'h01, 8'h05, 8'h00, 1'b1};
        vecs[1]  = '{8'h24, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 8'h05, 8'h00, 1'b1};
        vecs[2]  = '{8'h12, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h13, 8'h05, 8'h00, 1'b0};
        vecs[3]  = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{8'h12, 8'h30, 8'h45, 1'b1, 1'b0, 8'h12, 8'h30, 8'h45, 1'b1};
        vecs[5]  = '{8'h23, 8'h59, 8'h58, 1'b0, 1'b0, 8'h23, 8'h59, 8'h58, 1'b0};
        vecs[6]  = '{8'h09, 8'h0A, 8'h00, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 1'b0};
        vecs[7]  = '{8'h11, 8'h59, 8'h59, 1'b1, 1'b0, 8'h11, 8'h59, 8'h59, 1'b0};
        vecs[8]  = '{8'h00, 8'h60, 8'h00, 1'b1, 1'b1, 8'h11, 8'h59, 8'h59, 1'b0};
        vecs[9]  = '{8'h19, 8'h45, 8'h30, 1'b1, 1'b0, 8'h07, 8'h45, 8'h30, 1'b1};
        vecs[10] = '{8'h22, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1};
        vecs[11] = '{8'h1A, 8'h00, 8'h00, 1'b0, 1'b1, 8'h22, 8'h00, 8'h00, 1'b0};

        rst = 1'b1; ld = 1'b0; set = 1'b0; add = 1'b0; mode_12h = 1'b0;
        d_h = 8'h00; d_m = 8'h00; d_s = 8'h00;
`ifdef BCD_TIME_KEEPER_ALARM_EN
        alarm_h = 8'h00; alarm_m = 8'h01; alarm_arm = 1'b0; alarm_ack = 1'b0;
`endif
        repeat (2) cyc();

        // Reset state in both display modes.
        chk_time("reset", 8'h00, 8'h00, 8'h00);
        chk("reset setting", setting, 2'd0);
        chk("reset pm", pm, 1'b0);
        chk("reset sec_tick", sec_tick, 1'b0);
        mode_12h = 1'b1;
        #1;
        chk("reset hh12", hh, 8'h12);
        chk("reset pm12", pm, 1'b0);
        mode_12h = 1'b0;

        // First ticks land on cycles 4, 8, 12 after reset release.
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            #2;
            chk($sformatf("tick cycle %0d", k), sec_tick, (k % 4) == 0);
            cyc();
        end
        chk_time("after 12 cycles", 8'h00, 8'h00, 8'h03);

        // Table of loads: accepted values and 12h decode, rejected loads leave time alone.
        for (int i = 0; i < 12; i++) begin
            ld = 1'b1; d_h = vecs[i].h; d_m = vecs[i].m; d_s = vecs[i].s;
            mode_12h = vecs[i].mode;
            #2;
            chk($sformatf("vec%0d ld_err", i), ld_err, vecs[i].err);
            cyc();
            ld = 1'b0;
            chk_time($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es);
            chk($sformatf("vec%0d pm", i), pm, vecs[i].epm);
            chk($sformatf("vec%0d setting", i), setting, 2'd0);
        end

        // Day wrap: 23:59:58 -> 23:59:59 -> 00:00:00 with day_carry on the second tick.
        mode_12h = 1'b0;
        do_load(8'h23, 8'h59, 8'h58);
        for (int n = 1; n <= 8; n++) begin
            #2;
            chk($sformatf("wrap tick %0d", n), sec_tick, (n % 4) == 0);
            chk($sformatf("wrap day_carry %0d", n), day_carry, n == 8);
            cyc();
            if (n == 4) chk_time("wrap mid", 8'h23, 8'h59, 8'h59);
        end
        chk_time("wrap end", 8'h00, 8'h00, 8'h00);
        mode_12h = 1'b1;
        #1;
        chk("wrap hh12", hh, 8'h12);
        chk("wrap pm12", pm, 1'b0);
        mode_12h = 1'b0;

        // Set FSM: 25 adds in SET_H from 00, then one add each in SET_M and SET_S.
        do_load(8'h00, 8'h20, 8'h30);
        pulse_set();
        chk("set_h state", setting, 2'd1);
        add = 1'b1;
        for (int n = 0; n < 25; n++) cyc();
        add = 1'b0;
        chk_time("set_h adds", 8'h01, 8'h20, 8'h30);
        pulse_set();
        chk("set_m state", setting, 2'd2);
        add = 1'b1; cyc(); add = 1'b0;
        chk_time("set_m add", 8'h01, 8'h21, 8'h30);
        pulse_set();
        chk("set_s state", setting, 2'd3);
        add = 1'b1; cyc(); add = 1'b0;
        chk_time("set_s add", 8'h01, 8'h21, 8'h00);
        pulse_set();
        chk("back to run", setting, 2'd0);
        for (int n = 1; n <= 4; n++) begin
            #2;
            chk($sformatf("restart tick %0d", n), sec_tick, n == 4);
            cyc();
        end
        chk_time("restart", 8'h01, 8'h21, 8'h01);

        // Load beats a coincident set while in SET_M.
        pulse_set();
        pulse_set();
        chk("pre-ld state", setting, 2'd2);
        set = 1'b1;
        do_load(8'h05, 8'h06, 8'h07);
        set = 1'b0;
        chk("ld over set state", setting, 2'd0);
        chk_time("ld over set", 8'h05, 8'h06, 8'h07);

        // add in RUN is ignored.
        add = 1'b1; cyc(); add = 1'b0;
        chk_time("add in run", 8'h05, 8'h06, 8'h07);

        // Reset during SET_S with a rejected load and set pending: no pulses, back to 00:00:00.
        pulse_set(); pulse_set(); pulse_set();
        chk("pre-rst state", setting, 2'd3);
        rst = 1'b1; set = 1'b1; ld = 1'b1; d_h = 8'h24;
        #2;
        chk("rst ld_err", ld_err, 1'b0);
        chk("rst sec_tick", sec_tick, 1'b0);
        chk("rst day_carry", day_carry, 1'b0);
        cyc();
        rst = 1'b0; set = 1'b0; ld = 1'b0;
        chk("rst state", setting, 2'd0);
        chk_time("rst time", 8'h00, 8'h00, 8'h00);

`ifdef BCD_TIME_KEEPER_ALARM_EN
        alarm_h = 8'h00; alarm_m = 8'h01; alarm_arm = 1'b1;
        do_load(8'h00, 8'h00, 8'h59);
        for (int n = 1; n <= 3; n++) cyc();
        chk("alarm before", alarm, 1'b0);
        cyc();
        chk("alarm fire", alarm, 1'b1);
        chk_time("alarm time", 8'h00, 8'h01, 8'h00);
        cyc();
        chk("alarm held", alarm, 1'b1);
        alarm_ack = 1'b1; cyc(); alarm_ack = 1'b0;
        chk("alarm ack", alarm, 1'b0);
        for (int n = 0; n < 8; n++) cyc();
        chk("alarm no refire", alarm, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_time_keeper.md
Name: bcd_time_keeper

Overview:
- Parametrised successor to the team's 0-59/0-23 BCD counter chain: a full HH:MM:SS time-of-day keeper on one system clock.
- Second ticks come from an internal clock-enable prescaler; there is no derived clock and no asynchronous load.
- Adds a button-driven set FSM, a synchronous parallel load with range checking, and a runtime 12/24-hour display mode.
- Sits between the board clock and the 7-segment display driver.

Parameters:
- TICK_DIV, 50000, clk cycles per second tick; must be >= 2.
- CNT_W, 16, prescaler width; must satisfy 2**CNT_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld  in  1  single-cycle parallel load strobe.
- d_h  in  8  BCD hours for load (00-23, 24h form).
- d_m  in  8  BCD minutes for load (00-59).
- d_s  in  8  BCD seconds for load (00-59).
- set  in  1  single-cycle pulse; advances the set FSM.
- add  in  1  single-cycle pulse; increments the selected field.
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- hh  out  8  BCD hours as displayed (mode dependent).
- mm  out  8  BCD minutes.
- ss  out  8  BCD seconds.
- pm  out  1  PM flag; 0 in 24h mode.
- setting  out  2  FSM state code: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S.
- sec_tick  out  1  one-cycle pulse when seconds advance.
- day_carry  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.
- ld_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset: rst sampled at the clk rising edge. Internal time becomes 00:00:00, FSM RUN, prescaler 0. All pulse outputs are 0. After reset, hh=00 (24h) or 12 with pm=0 (12h).
- Storage: internal time is always 24h BCD, six 4-bit digits. Each low digit wraps 9->0 and carries into its high digit.
- Prescaler (RUN only): counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and asserts sec_tick for that cycle. Time advances on the same edge.
- Tick ordering: the first sec_tick after reset occurs TICK_DIV cycles after rst deasserts.
- Carry chain: ss 59->00 increments mm; mm 59->00 increments hh; hh 23->00 when mm and ss wrap. day_carry is coincident with the sec_tick that produces 00:00:00.
- Set FSM: set moves RUN->SET_H->SET_M->SET_S->RUN.
- In any SET state: prescaler held at 0, no sec_tick, time frozen.
- add in SET_H: hh increments mod 24.
- add in SET_M: mm increments mod 60.
- add in SET_S: ss is cleared to 00.
- add never carries into another field. add in RUN is ignored.
- Leaving SET_S: the transition to RUN restarts the prescaler at 0, so the next tick is TICK_DIV cycles later.
- Load, valid: accepted when every nibble is <= 9, d_h <= 23, d_m <= 59 and d_s <= 59. Time takes the load value on the next edge, the FSM is forced to RUN, and the prescaler clears.
- Load, invalid: time, FSM and prescaler are unchanged, and ld_err pulses for one cycle.
- Priority in one cycle: rst > ld > set > add > prescaler tick. A set or add coincident with ld is dropped. A tick coincident with a set that leaves RUN is dropped.
- 12h display, combinational from internal hours:
  - 00 -> 12, pm=0
  - 01-11 -> same value, pm=0
  - 12 -> 12, pm=1
  - 13-23 -> h-12, pm=1
- mode_12h may change at any time; it affects only hh and pm, never the internal state.
- Reset mid-set or mid-count: returns to RUN at 00:00:00 with no residual pulses.

Optional Feature:
- Macro BCD_TIME_KEEPER_ALARM_EN.
- Defined:
  - Added ports: alarm_h (8, BCD 24h), alarm_m (8), alarm_arm (1), alarm_ack (1), alarm (1 out).
  - alarm sets on the sec_tick that makes time equal alarm_h:alarm_m:00, while alarm_arm=1 and the FSM is in RUN.
  - alarm stays high until alarm_ack, rst, or alarm_arm=0.
  - ack has priority over a coincident match.
- Not defined: these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package:
  - FSM state typedef (RUN/SET_H/SET_M/SET_S with the codes above).
  - BCD limit constants: SEC_MAX 8'h59, MIN_MAX 8'h59, HR_MAX 8'h23.
  - The 12h conversion function.
- Sub-module bcd_mod_counter:
  - Two-digit BCD counter, parameter MAX.
  - Inputs: clk, rst, inc, clr, ld, d.
  - Outputs: q, carry (high when q==MAX and inc).
  - Instantiated three times.

Test Plan:
- TICK_DIV=4, release rst -> hh/mm/ss=00/00/00 and sec_tick on cycles 4, 8, 12; ss=03 after 12 cycles.
- ld d=23:59:58, run 2 ticks -> 23:59:59, then 00:00:00 with day_carry and sec_tick coincident; mode_12h=1 then shows hh=12, pm=0.
- ld d=13:05:00 with mode_12h=1 -> hh=01, pm=1; ld d=24:00:00 or d_m=8'h5A -> ld_err pulse, time unchanged.
- set, add x25 -> SET_H, hh wraps 00->...->23->00 ending at 01, mm unchanged; set x3 -> RUN, next tick exactly 4 cycles later.
- ld and set in the same cycle at SET_M -> load taken, FSM=RUN, set ignored; rst during SET_S -> RUN at 00:00:00.
- With ALARM_EN: alarm 00:01, arm=1, ld 00:00:59 -> alarm rises on next tick; alarm_ack -> low; no re-fire until the next match.
